extend: RTL
===========

# extend

Streaming sign-extension stage that widens signed fixed-point words from ARGW to RESW bits, with an optional left shift for fractional-point alignment. It is the inverse-direction companion of the saturating narrowing stage: narrow activations and weights are widened back to accumulator width before they enter multiply/accumulate datapaths. Both sides use the codebase's valid/ready stream handshake. A two-entry skid buffer gives full throughput and fully registered outputs.

## Interface
- ARGW, 16, input word width in bits; must satisfy ARGW + SHIFT <= RESW
- RESW, 24, output word width in bits
- SHIFT, 0, left shift applied after sign extension, 0..RESW-ARGW
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- arg_valid  input  1  input word present
- arg_data  input  ARGW  signed input word
- arg_ready  output  1  block can accept a word this cycle
- res_valid  output  1  output word present
- res_data  output  RESW  signed widened word
- res_ready  input  1  downstream accepts the word this cycle

## Operation
- Transfer on a side occurs in any cycle where valid && ready are both high at the clock edge.
- Arithmetic: res = sign_extend(arg, RESW) << SHIFT. Vacated LSBs are zero. No overflow is possible under the parameter constraint. ARGW + SHIFT > RESW is a parameter error: elaboration fails via $error.
- Buffer states:
  - EMPTY: output register invalid.
  - BUSY: output register holds one word.
  - FULL: output register and skid register each hold a word.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY, in -> BUSY.
  - BUSY, in && !out -> FULL.
  - BUSY, out && !in -> EMPTY.
  - BUSY, in && out -> BUSY; the new word is loaded into the output register.
  - FULL, out -> BUSY; the skid word moves to the output register.
  - No input transfer is possible in FULL.
- Ordering is strict FIFO. No word is dropped or duplicated.
- Output rules:
  - res_valid = (state != EMPTY).
  - arg_ready = (state != FULL) && !rst.
  - Both are driven from registers, with no combinational path from res_ready to arg_ready.
- Stability: while res_valid && !res_ready, res_data is held stable.
- Reset values: state EMPTY, res_valid 0, res_data 0, arg_ready 0 while rst is high.
- Reset mid-operation discards all buffered words. There is no output transfer in the reset cycle.

## Timing
- Latency: a word accepted at edge N is presented with res_valid high from edge N (visible in cycle N+1).
- Throughput: one word per cycle while res_ready is held high.
- Backpressure: after res_ready drops, at most one further input is accepted (into the skid register), then arg_ready falls on the following edge.
- Recovery: arg_ready rises the cycle after FULL drains to BUSY.
- Empty-to-full bubble: none.
- Post-reset: arg_ready is high in the first cycle after rst deasserts.

## Structure
- Shared stream package: the buffer-state enum (EMPTY, BUSY, FULL), for reuse by other handshake stages.
- Sub-module `skid`: a width-parameterised two-entry skid buffer holding the handshake FSM and registers.
- `extend` itself is the combinational widen/shift feeding `skid`.
- No other constants are shared.

## Test plan
- Defaults, single transfers with res_ready high:
  - 16'h00ff -> 24'h0000ff
  - 16'hff00 -> 24'hffff00
  - 16'h7fff -> 24'h007fff
  - 16'h8000 -> 24'hff8000
  - Each appears one cycle after acceptance.
- SHIFT=4 build:
  - 16'h8000 -> 24'hf80000
  - 16'h0001 -> 24'h000010
  - 16'hffff -> 24'hfffff0
- Stream 16'h0001..16'h0008 back-to-back, res_ready high -> eight outputs on consecutive cycles, in order, arg_ready never low.
- Hold res_ready low while sending 16'h0001, 16'h0002, 16'h0003:
  - 16'h0001 and 16'h0002 are accepted; arg_ready goes low.
  - res_data is held at 24'h000001.
  - Raising res_ready yields 24'h000001, 24'h000002, 24'h000003 in order with no loss.
- Assert rst in FULL:
  - The next cycle shows res_valid 0, res_data 0, arg_ready 0.
  - After deassert, arg_ready is 1 and stale words are never emitted.
- Randomised valid/res_ready toggling over 1000 words -> the output sequence equals the reference model, with no drops or duplicates.

Source files
------------

// File: rtl/extend_pkg.sv
// Handshake buffer-state encoding, shared by valid/ready stream stages.
package extend_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/extend_skid.sv
// Two-entry skid buffer: registered res_valid/res_data, arg_ready from state only.
//   state | meaning
//   EMPTY | output register invalid
//   BUSY  | output register holds one word
//   FULL  | output and skid registers both hold a word
module skid
  import extend_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_valid,
  input  logic [W-1:0] arg_data,
  output logic         arg_ready,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  input  logic         res_ready
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] out_q, skid_q;
  logic         xfer_in, xfer_out;
  logic         load_arg, load_skid, skid_to_out;

  assign arg_ready = (state_q != FULL) && !rst;
  assign res_valid = (state_q != EMPTY);
  assign res_data  = out_q;
  assign xfer_in   = arg_valid && arg_ready;
  assign xfer_out  = res_valid && res_ready;

  always_comb begin
    state_d     = state_q;
    load_arg    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          state_d  = BUSY;
          load_arg = 1'b1;
        end
      end
      BUSY: begin
        if (xfer_in && !xfer_out) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (xfer_in && xfer_out) begin
          load_arg = 1'b1;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer_out) begin
          state_d     = BUSY;
          skid_to_out = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_arg)
        out_q <= arg_data;
      else if (skid_to_out)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= arg_data;
    end
  end

endmodule

// File: rtl/extend.sv
// Sign-extends ARGW-bit words to RESW bits, shifts left by SHIFT, and streams
// them through a skid buffer.
module extend
  import extend_pkg::*;
#(
  parameter int ARGW  = 16,
  parameter int RESW  = 24,
  parameter int SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_valid,
  input  logic [ARGW-1:0] arg_data,
  output logic            arg_ready,
  output logic            res_valid,
  output logic [RESW-1:0] res_data,
  input  logic            res_ready
);

  if (ARGW + SHIFT > RESW) begin : g_param_err
    $error("extend: ARGW + SHIFT exceeds RESW");
  end

  logic [RESW-1:0] ext;
  logic [RESW-1:0] widened;

  assign ext     = RESW'($signed(arg_data));
  assign widened = ext << SHIFT;

  skid #(.W(RESW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_data  (widened),
    .arg_ready (arg_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready)
  );

endmodule
